// File: rtl/dominion_pkg.sv
// Shared widths, phase encoding and saturating adders for the Dominion turn engine.
package dominion_pkg;

  localparam int unsigned MODE_W = 3;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned COIN_W = 5;

  // Encoding is the mode bus value seen by card_control_TOP.
  typedef enum logic [MODE_W-1:0] {
    StIdle      = 3'd0,
    StStart     = 3'd1,
    StAction    = 3'd2,
    StActionEnd = 3'd3,
    StBuy       = 3'd4,
    StDraw      = 3'd5,
    StEndgame   = 3'd6
  } mode_e;

  // a + b clamped to 15.
  function automatic logic [CNT_W-1:0] sat_add_cnt(input logic [CNT_W-1:0] a,
                                                   input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // coins + b clamped to 31.
  function automatic logic [COIN_W-1:0] sat_add_coin(input logic [COIN_W-1:0] a,
                                                     input logic [CNT_W-1:0]  b);
    logic [COIN_W:0] s;
    s = {1'b0, a} + {2'b00, b};
    return s[COIN_W] ? {COIN_W{1'b1}} : s[COIN_W-1:0];
  endfunction

endpackage

// File: rtl/turn_resource_regs.sv
// Per-turn resource registers (actions, buys, coins) with reload, card-effect,
// treasure-add and purchase controls. Reload has the highest priority.
module turn_resource_regs
  import dominion_pkg::*;
#(
  parameter int unsigned StartActions = 1,
  parameter int unsigned StartBuys    = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              reload_i,
  input  logic              play_i,
  input  logic              coin_add_i,
  input  logic              buy_i,
  input  logic [CNT_W-1:0]  eff_actions_i,
  input  logic [CNT_W-1:0]  eff_buys_i,
  input  logic [CNT_W-1:0]  eff_coins_i,
  input  logic [CNT_W-1:0]  card_cost_i,
  output logic [CNT_W-1:0]  actions_o,
  output logic [CNT_W-1:0]  buys_o,
  output logic [COIN_W-1:0] coins_o,
  output logic [CNT_W-1:0]  play_actions_o
);

  logic [CNT_W-1:0]  actions_q, actions_d;
  logic [CNT_W-1:0]  buys_q, buys_d;
  logic [COIN_W-1:0] coins_q, coins_d;

  // Playing a card spends one action; only meaningful while actions_q != 0.
  assign play_actions_o = sat_add_cnt(actions_q - CNT_W'(1), eff_actions_i);

  // Next-state selection for the three resource counters.
  always_comb begin
    actions_d = actions_q;
    buys_d    = buys_q;
    coins_d   = coins_q;
    if (reload_i) begin
      actions_d = CNT_W'(StartActions);
      buys_d    = CNT_W'(StartBuys);
      coins_d   = '0;
    end else if (play_i) begin
      actions_d = play_actions_o;
      buys_d    = sat_add_cnt(buys_q, eff_buys_i);
      coins_d   = sat_add_coin(coins_q, eff_coins_i);
    end else if (coin_add_i) begin
      coins_d   = sat_add_coin(coins_q, eff_coins_i);
    end else if (buy_i) begin
      // Caller guarantees buys_q != 0 and coins_q >= card_cost_i.
      buys_d    = buys_q - CNT_W'(1);
      coins_d   = coins_q - COIN_W'(card_cost_i);
    end
  end

  // Resource state registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      actions_q <= '0;
      buys_q    <= '0;
      coins_q   <= '0;
    end else begin
      actions_q <= actions_d;
      buys_q    <= buys_d;
      coins_q   <= coins_d;
    end
  end

  assign actions_o = actions_q;
  assign buys_o    = buys_q;
  assign coins_o   = coins_q;

endmodule

// File: rtl/turn_phase_ctrl.sv
// Dominion turn sequencer: phase FSM driving the mode bus, turn/player tracking
// and the play/buy enables.
module turn_phase_ctrl
  import dominion_pkg::*;
#(
  parameter int unsigned HandSize     = 5,
  parameter int unsigned StartActions = 1,
  parameter int unsigned StartBuys    = 1,
  parameter int unsigned NumPlayers   = 2,
  parameter logic [7:0]  MaxTurns     = 8'd60
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              but_sel_i,
  input  logic              but_end_i,
  input  logic              end_mode_i,
  input  logic              eff_valid_i,
  input  logic [CNT_W-1:0]  eff_actions_i,
  input  logic [CNT_W-1:0]  eff_buys_i,
  input  logic [CNT_W-1:0]  eff_coins_i,
  input  logic [CNT_W-1:0]  eff_draw_i,
  input  logic              bought_i,
  input  logic [CNT_W-1:0]  card_cost_i,
  input  logic              game_over_in_i,
  output logic [MODE_W-1:0] mode_o,
  output logic [CNT_W-1:0]  draw_count_o,
  output logic              play_en_o,
  output logic              can_buy_o,
  output logic [CNT_W-1:0]  actions_o,
  output logic [CNT_W-1:0]  buys_o,
  output logic [COIN_W-1:0] coins_o,
  output logic [7:0]        turn_count_o,
  output logic [1:0]        player_o
);

  mode_e            state_q, state_d;
  logic [CNT_W-1:0] draw_count_q, draw_count_d;
  logic [7:0]       turn_count_q, turn_count_d;
  logic [1:0]       player_q, player_d;
  logic             ret_action_q, ret_action_d;

  logic             reload, play, coin_add, buy;
  logic [CNT_W-1:0] play_actions;
  logic             purchase;
  logic [7:0]       new_turn;
  logic [1:0]       next_player;

  turn_resource_regs #(
    .StartActions(StartActions),
    .StartBuys   (StartBuys)
  ) u_res (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .reload_i      (reload),
    .play_i        (play),
    .coin_add_i    (coin_add),
    .buy_i         (buy),
    .eff_actions_i (eff_actions_i),
    .eff_buys_i    (eff_buys_i),
    .eff_coins_i   (eff_coins_i),
    .card_cost_i   (card_cost_i),
    .actions_o     (actions_o),
    .buys_o        (buys_o),
    .coins_o       (coins_o),
    .play_actions_o(play_actions)
  );

  assign play_en_o   = (state_q == StAction) && (actions_o != '0);
  assign can_buy_o   = (state_q == StBuy) && (buys_o != '0) &&
                       (coins_o >= COIN_W'(card_cost_i));
  assign purchase    = bought_i && can_buy_o;
  assign new_turn    = (turn_count_q == 8'hFF) ? turn_count_q : turn_count_q + 8'd1;
  assign next_player = (player_q == 2'(NumPlayers - 1)) ? 2'd0 : player_q + 2'd1;

  // Phase transitions and turn bookkeeping.
  always_comb begin
    state_d      = state_q;
    draw_count_d = draw_count_q;
    turn_count_d = turn_count_q;
    player_d     = player_q;
    ret_action_d = ret_action_q;
    reload       = 1'b0;
    play         = 1'b0;
    coin_add     = 1'b0;
    buy          = 1'b0;
    case (state_q)
      StIdle: begin
        if (but_sel_i) state_d = StStart;
      end
      StStart: begin
        if (end_mode_i) begin
          state_d      = StDraw;
          draw_count_d = CNT_W'(HandSize);
          ret_action_d = 1'b0;
          reload       = 1'b1;
        end
      end
      StDraw: begin
        // Both a fresh hand and a mid-action draw resume in ACTION.
        if (end_mode_i) begin
          state_d      = StAction;
          ret_action_d = 1'b0;
        end
      end
      StAction: begin
        if (eff_valid_i && (actions_o != '0)) begin
          play = 1'b1;
          if (eff_draw_i != '0) begin
            // A pending draw wins over but_end and the out-of-actions exit.
            state_d      = StDraw;
            draw_count_d = eff_draw_i;
            ret_action_d = 1'b1;
          end else if (but_end_i || (play_actions == '0)) begin
            state_d = StActionEnd;
          end
        end else if (but_end_i) begin
          state_d = StActionEnd;
        end
      end
      StActionEnd: begin
        coin_add = eff_valid_i;
        if (end_mode_i) state_d = StBuy;
      end
      StBuy: begin
        buy = purchase;
        if (but_end_i || (purchase && (buys_o == CNT_W'(1)))) begin
          turn_count_d = new_turn;
          if (game_over_in_i || (new_turn == MaxTurns)) begin
            state_d = StEndgame;
          end else begin
            state_d      = StDraw;
            draw_count_d = CNT_W'(HandSize);
            ret_action_d = 1'b0;
            player_d     = next_player;
            reload       = 1'b1;
          end
        end
      end
      StEndgame: ;
      default: state_d = StIdle;
    endcase
  end

  // Phase and turn registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      draw_count_q <= '0;
      turn_count_q <= '0;
      player_q     <= '0;
      ret_action_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      draw_count_q <= draw_count_d;
      turn_count_q <= turn_count_d;
      player_q     <= player_d;
      ret_action_q <= ret_action_d;
    end
  end

  assign mode_o       = state_q;
  assign draw_count_o = draw_count_q;
  assign turn_count_o = turn_count_q;
  assign player_o     = player_q;

endmodule

// File: tb/tb_turn_phase_ctrl.sv
// Self-checking bench for turn_phase_ctrl using an expected-snapshot scoreboard.
module tb_turn_phase_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       but_sel, but_end, end_mode, eff_valid, bought, game_over_in;
  logic [3:0] eff_actions, eff_buys, eff_coins, eff_draw, card_cost;
  logic [2:0] mode;
  logic [3:0] draw_count, actions, buys;
  logic       play_en, can_buy;
  logic [4:0] coins;
  logic [7:0] turn_count;
  logic [1:0] player;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb[$];

  localparam logic [4:0] PSel = 5'b10000;
  localparam logic [4:0] PEnd = 5'b01000;
  localparam logic [4:0] PEm  = 5'b00100;
  localparam logic [4:0] PEv  = 5'b00010;
  localparam logic [4:0] PBt  = 5'b00001;

  typedef struct packed {
    logic [4:0] p;
    logic [3:0] ea, eb, ec, ed, cost;
    logic       go;
  } stim_t;

  turn_phase_ctrl dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .but_sel_i     (but_sel),
    .but_end_i     (but_end),
    .end_mode_i    (end_mode),
    .eff_valid_i   (eff_valid),
    .eff_actions_i (eff_actions),
    .eff_buys_i    (eff_buys),
    .eff_coins_i   (eff_coins),
    .eff_draw_i    (eff_draw),
    .bought_i      (bought),
    .card_cost_i   (card_cost),
    .game_over_in_i(game_over_in),
    .mode_o        (mode),
    .draw_count_o  (draw_count),
    .play_en_o     (play_en),
    .can_buy_o     (can_buy),
    .actions_o     (actions),
    .buys_o        (buys),
    .coins_o       (coins),
    .turn_count_o  (turn_count),
    .player_o      (player)
  );

  always #5 clk = ~clk;

  // Expected snapshot: mode, draw, play_en, can_buy, actions, buys, coins, turn, player.
  function automatic logic [31:0] pk(int m, int d, int pe, int cb, int a, int b, int c,
                                     int t, int p);
    return {3'(m), 4'(d), 1'(pe), 1'(cb), 4'(a), 4'(b), 5'(c), 8'(t), 2'(p)};
  endfunction

  function automatic logic [31:0] obs();
    return {mode, draw_count, play_en, can_buy, actions, buys, coins, turn_count, player};
  endfunction

  function automatic stim_t mk(logic [4:0] p, int ea, int eb, int ec, int ed, int cost,
                               int go);
    stim_t s;
    s.p = p; s.ea = 4'(ea); s.eb = 4'(eb); s.ec = 4'(ec); s.ed = 4'(ed);
    s.cost = 4'(cost); s.go = 1'(go);
    return s;
  endfunction

  task automatic drive(input stim_t s);
    {but_sel, but_end, end_mode, eff_valid, bought} = s.p;
    eff_actions = s.ea; eff_buys = s.eb; eff_coins = s.ec; eff_draw = s.ed;
    card_cost = s.cost; game_over_in = s.go;
  endtask

  // One clock edge, then drop all single-cycle pulses.
  task automatic cyc();
    @(posedge clk);
    #1;
    {but_sel, but_end, end_mode, eff_valid, bought} = '0;
  endtask

  task automatic test_reset();
    logic [31:0] ex;
    reset = 1'b1;
    drive(mk(5'b0, 0, 0, 0, 0, 7, 0));
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    ex = sb.pop_front();
    total++;
    if (obs() !== ex) begin
      bad++;
      $display("FAIL reset: got %h want %h", obs(), ex);
    end
    reset = 1'b0;
  endtask

  task automatic test_first_turn();
    stim_t st[$];
    logic [31:0] ex;
    st.push_back(mk(PSel, 0, 0, 0, 0, 7, 0));      sb.push_back(pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    st.push_back(mk(PEm, 0, 0, 0, 0, 7, 0));       sb.push_back(pk(5, 5, 0, 0, 1, 1, 0, 0, 0));
    st.push_back(mk(PEm, 0, 0, 0, 0, 7, 0));       sb.push_back(pk(2, 5, 1, 0, 1, 1, 0, 0, 0));
    st.push_back(mk(PEv, 2, 0, 2, 1, 7, 0));       sb.push_back(pk(5, 1, 0, 0, 2, 1, 2, 0, 0));
    st.push_back(mk(PEm, 0, 0, 0, 0, 7, 0));       sb.push_back(pk(2, 1, 1, 0, 2, 1, 2, 0, 0));
    st.push_back(mk(PEnd, 0, 0, 0, 0, 7, 0));      sb.push_back(pk(3, 1, 0, 0, 2, 1, 2, 0, 0));
    st.push_back(mk(PEv | PEm, 0, 0, 4, 0, 7, 0)); sb.push_back(pk(4, 1, 0, 0, 2, 1, 6, 0, 0));
    foreach (st[i]) begin
      drive(st[i]);
      cyc();
      ex = sb.pop_front();
      total++;
      if (obs() !== ex) begin
        bad++;
        $display("FAIL first_turn[%0d]: got %h want %h", i, obs(), ex);
      end
    end
  endtask

  task automatic test_buy();
    logic [31:0] ex;
    // Too expensive: can_buy low, purchase ignored.
    drive(mk(PBt, 0, 0, 0, 0, 7, 0));
    sb.push_back(pk(4, 1, 0, 0, 2, 1, 6, 0, 0));
    cyc();
    ex = sb.pop_front();
    total++;
    if (obs() !== ex) begin
      bad++;
      $display("FAIL buy_expensive: got %h want %h", obs(), ex);
    end
    // Cheaper pile: can_buy follows card_cost without a clock edge.
    card_cost = 4'd5;
    sb.push_back(pk(4, 1, 0, 1, 2, 1, 6, 0, 0));
    #1;
    ex = sb.pop_front();
    total++;
    if (obs() !== ex) begin
      bad++;
      $display("FAIL buy_can_buy: got %h want %h", obs(), ex);
    end
    // Last buy spent: turn ends, next player's hand.
    drive(mk(PBt, 0, 0, 0, 0, 5, 0));
    sb.push_back(pk(5, 5, 0, 0, 1, 1, 0, 1, 1));
    cyc();
    ex = sb.pop_front();
    total++;
    if (obs() !== ex) begin
      bad++;
      $display("FAIL buy_turn_end: got %h want %h", obs(), ex);
    end
  endtask

  task automatic test_saturation();
    stim_t st[$];
    logic [31:0] ex;
    st.push_back(mk(PEm, 0, 0, 0, 0, 5, 0));   sb.push_back(pk(2, 5, 1, 0, 1, 1, 0, 1, 1));
    st.push_back(mk(PEv, 15, 0, 15, 0, 5, 0)); sb.push_back(pk(2, 5, 1, 0, 15, 1, 15, 1, 1));
    st.push_back(mk(PEv, 3, 0, 15, 0, 5, 0));  sb.push_back(pk(2, 5, 1, 0, 15, 1, 30, 1, 1));
    st.push_back(mk(PEv, 3, 15, 4, 0, 5, 0));  sb.push_back(pk(2, 5, 1, 0, 15, 15, 31, 1, 1));
    foreach (st[i]) begin
      drive(st[i]);
      cyc();
      ex = sb.pop_front();
      total++;
      if (obs() !== ex) begin
        bad++;
        $display("FAIL saturation[%0d]: got %h want %h", i, obs(), ex);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[$];
    logic [31:0] ex;
    st.push_back(mk(PEv | PEnd, 0, 0, 0, 2, 5, 0)); sb.push_back(pk(5, 2, 0, 0, 14, 15, 31, 1, 1));
    st.push_back(mk(PEm, 0, 0, 0, 0, 5, 0));        sb.push_back(pk(2, 2, 1, 0, 14, 15, 31, 1, 1));
    st.push_back(mk(PEnd, 0, 0, 0, 0, 5, 0));       sb.push_back(pk(3, 2, 0, 0, 14, 15, 31, 1, 1));
    st.push_back(mk(PEm, 0, 0, 0, 0, 5, 0));        sb.push_back(pk(4, 2, 0, 1, 14, 15, 31, 1, 1));
    st.push_back(mk(PBt, 0, 0, 0, 0, 5, 0));        sb.push_back(pk(4, 2, 0, 1, 14, 14, 26, 1, 1));
    st.push_back(mk(PBt | PEnd, 0, 0, 0, 0, 5, 0)); sb.push_back(pk(5, 5, 0, 0, 1, 1, 0, 2, 0));
    foreach (st[i]) begin
      drive(st[i]);
      cyc();
      ex = sb.pop_front();
      total++;
      if (obs() !== ex) begin
        bad++;
        $display("FAIL back_to_back[%0d]: got %h want %h", i, obs(), ex);
      end
    end
  endtask

  task automatic test_endgame();
    stim_t st[$];
    logic [31:0] ex;
    st.push_back(mk(PEm, 0, 0, 0, 0, 5, 0));      sb.push_back(pk(2, 5, 1, 0, 1, 1, 0, 2, 0));
    st.push_back(mk(PEv, 0, 0, 3, 0, 5, 0));      sb.push_back(pk(3, 5, 0, 0, 0, 1, 3, 2, 0));
    st.push_back(mk(PEm, 0, 0, 0, 0, 5, 0));      sb.push_back(pk(4, 5, 0, 0, 0, 1, 3, 2, 0));
    st.push_back(mk(PEnd, 0, 0, 0, 0, 5, 1));     sb.push_back(pk(6, 5, 0, 0, 0, 1, 3, 3, 0));
    st.push_back(mk(5'b11111, 1, 1, 1, 1, 5, 1)); sb.push_back(pk(6, 5, 0, 0, 0, 1, 3, 3, 0));
    st.push_back(mk(PEm | PEv, 1, 1, 1, 0, 0, 0)); sb.push_back(pk(6, 5, 0, 0, 0, 1, 3, 3, 0));
    foreach (st[i]) begin
      drive(st[i]);
      cyc();
      ex = sb.pop_front();
      total++;
      if (obs() !== ex) begin
        bad++;
        $display("FAIL endgame[%0d]: got %h want %h", i, obs(), ex);
      end
    end
  endtask

  task automatic test_async_reset();
    stim_t st[$];
    logic [31:0] ex;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    st.push_back(mk(PSel, 0, 0, 0, 0, 0, 0)); sb.push_back(pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    st.push_back(mk(PEm, 0, 0, 0, 0, 0, 0));  sb.push_back(pk(5, 5, 0, 0, 1, 1, 0, 0, 0));
    st.push_back(mk(PEm, 0, 0, 0, 0, 0, 0));  sb.push_back(pk(2, 5, 1, 0, 1, 1, 0, 0, 0));
    foreach (st[i]) begin
      drive(st[i]);
      cyc();
      ex = sb.pop_front();
      total++;
      if (obs() !== ex) begin
        bad++;
        $display("FAIL async_reset_setup[%0d]: got %h want %h", i, obs(), ex);
      end
    end
    // Assert reset between edges; outputs must clear before the next edge.
    @(posedge clk);
    #3;
    reset = 1'b1;
    sb.push_back(pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    ex = sb.pop_front();
    total++;
    if (obs() !== ex) begin
      bad++;
      $display("FAIL async_reset: got %h want %h", obs(), ex);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_max_turns();
    logic [31:0] ex;
    drive(mk(PSel, 0, 0, 0, 0, 0, 0)); cyc();
    drive(mk(PEm, 0, 0, 0, 0, 0, 0));  cyc();
    for (int t = 0; t < 60; t++) begin
      drive(mk(PEm, 0, 0, 0, 0, 0, 0));  cyc();
      drive(mk(PEnd, 0, 0, 0, 0, 0, 0)); cyc();
      drive(mk(PEm, 0, 0, 0, 0, 0, 0));  cyc();
      drive(mk(PEnd, 0, 0, 0, 0, 0, 0));
      if (t == 58) sb.push_back(pk(5, 5, 0, 0, 1, 1, 0, 59, 1));
      if (t == 59) sb.push_back(pk(6, 5, 0, 0, 1, 1, 0, 60, 1));
      cyc();
      if (t >= 58) begin
        ex = sb.pop_front();
        total++;
        if (obs() !== ex) begin
          bad++;
          $display("FAIL max_turns[%0d]: got %h want %h", t, obs(), ex);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(mk(5'b0, 0, 0, 0, 0, 0, 0));
    test_reset();
    test_first_turn();
    test_buy();
    test_saturation();
    test_back_to_back();
    test_endgame();
    test_async_reset();
    test_max_turns();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/turn_phase_ctrl.md
Name: turn_phase_ctrl

Overview:
Turn sequencer for the Dominion card engine. Drives the 3-bit `mode` bus consumed by card_control_TOP through START → DRAW → ACTION → ACTIONEND → BUY → DRAW … → ENDGAME. Tracks per-turn resources (actions, buys, coins), turn count and active player. Decides `can_buy` from coins, buys and the cost of the selected pile. Sits between the button/switch front end, the card handler and the supply-pile tracker.

Parameters:
HAND_SIZE, 5, cards drawn at the start of each turn (4 bits)
START_ACTIONS, 1, actions loaded at turn start
START_BUYS, 1, buys loaded at turn start
NUM_PLAYERS, 2, players rotated at turn end (1–4)
MAX_TURNS, 8'd60, turn_count value that forces ENDGAME

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
but_sel  in  1  one-cycle pulse, start game (IDLE only)
but_end  in  1  one-cycle pulse, end current phase (ACTION, BUY)
end_mode  in  1  pulse from card handler, current mode's operation finished
eff_valid  in  1  pulse, card effect / treasure total valid
eff_actions  in  4  +actions of played card
eff_buys  in  4  +buys of played card
eff_coins  in  4  +coins (card effect or treasure total)
eff_draw  in  4  cards to draw from played card
bought  in  1  pulse, handler gained selected card
card_cost  in  4  cost of pile selected by card_sel_sw
game_over_in  in  1  supply tracker: province pile empty or ≥3 piles empty
mode  out  3  0 IDLE, 1 START, 2 ACTION, 3 ACTIONEND, 4 BUY, 5 DRAW, 6 ENDGAME
draw_count  out  4  cards to draw while mode = DRAW
play_en  out  1  state = ACTION and actions ≠ 0
can_buy  out  1  state = BUY and buys ≠ 0 and coins ≥ card_cost
actions  out  4  remaining actions
buys  out  4  remaining buys
coins  out  5  available coins
turn_count  out  8  completed turns
player  out  2  active player index

Behaviour:
- Reset (async): state IDLE, mode 0, all counters 0, player 0, can_buy 0, play_en 0, ret_action 0.
- `mode` is the state register itself; every transition takes effect on the next clk edge.
- `play_en` and `can_buy` are combinational decodes of the registers and `card_cost`.
- IDLE: on but_sel → START.
- START: on end_mode → DRAW.
  - draw_count = HAND_SIZE
  - actions = START_ACTIONS, buys = START_BUYS, coins = 0, ret_action = 0
- DRAW: on end_mode:
  - ret_action = 0 → ACTION
  - ret_action = 1 → ACTION, and clear ret_action
- ACTION: on eff_valid while actions ≠ 0:
  - actions = sat15(actions − 1 + eff_actions)
  - buys = sat15(buys + eff_buys)
  - coins = sat31(coins + eff_coins)
  - if eff_draw ≠ 0: → DRAW, draw_count = eff_draw, ret_action = 1
  - eff_valid while actions = 0 is ignored.
- Leaving ACTION:
  - but_end → ACTIONEND.
  - But if eff_valid arrives in the same cycle as but_end, apply the effect; eff_draw ≠ 0 takes priority and goes to DRAW.
  - Otherwise, when the updated actions reach 0 with no draw pending, go to ACTIONEND on the same edge.
- ACTIONEND: the handler totals treasures.
  - eff_valid: coins = sat31(coins + eff_coins).
  - end_mode → BUY.
  - If both arrive in the same cycle, apply the coins, then move to BUY.
- BUY: bought while can_buy = 1 → buys −= 1, coins −= card_cost. bought while can_buy = 0 is ignored, so coins never underflow.
- Turn end, triggered by but_end, or by buys reaching 0 after a purchase (a purchase and but_end in the same cycle apply the purchase first):
  - turn_count + 1 saturates at 255.
  - If game_over_in = 1 or the new turn_count = MAX_TURNS → ENDGAME.
  - Otherwise → DRAW, with draw_count = HAND_SIZE, actions/buys/coins reloaded as in START, and player = (player + 1) mod NUM_PLAYERS.
- ENDGAME: terminal; all counters hold; only reset exits.
- Unexpected end_mode or eff_valid in other states is ignored.
- Reset asserted mid-phase returns to IDLE immediately, without waiting for a clk edge.

Decomposition:
- Package dominion_pkg:
  - mode constants IDLE=0, START=1, ACTION=2, ACTIONEND=3, BUY=4, DRAW=5, ENDGAME=6
  - MODE_W=3, CNT_W=4, COIN_W=5
  - sat-add functions
- Sub-module turn_resource_regs: holds actions, buys and coins with saturating add, decrement and reload controls. It is driven by the FSM in turn_phase_ctrl.

Test Plan:
1. Reset, but_sel → mode 1; end_mode → mode 5, draw_count 5; end_mode → mode 2 with actions 1, buys 1, coins 0, play_en 1.
2. In ACTION, eff_valid with actions+2, coins+2, draw 1 → actions 2, coins 2, mode 5, draw_count 1; end_mode → mode 2. Then but_end → mode 3.
3. In ACTIONEND, eff_valid with coins 4 and end_mode in the same cycle → mode 4, coins 6.
4. In BUY with card_cost 7 → can_buy 0 and bought is ignored. With card_cost 5 → can_buy 1; bought → next cycle mode 5, turn_count 1, player 1, actions 1, buys 1, coins 0.
5. Saturation: coins 30 plus eff_coins 4 → coins 31; actions 15 plus eff_actions 3 → 15.
6. game_over_in = 1 at turn end → mode 6 and holds under further pulses. Reset asserted mid-ACTION between clk edges → mode 0 immediately.
